// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-side memory responder.
//   - Access size codes driven by the CPU memory-access stage.
//   - READ/WRITE polarity of MEM_ACCESS_READ_WRN.
//   - Loader FSM state encodings.
//   - Helper that turns (size, address LSBs) into byte-lane enables.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_RSVD = 2'b11   // treated as a word access
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_LOAD  = 2'b10
  } ld_state_e;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  // Little-endian lane enables for a store of the given size at byte offset a.
  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                              input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      SIZE_BYTE: be = 4'b0001 << a;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_ram.sv
// Synchronous 32-bit RAM with four byte-lane write enables and a registered
// read. Kept separate so the storage can be swapped for a technology macro.
//   clk, rst_n        : clock, async active-low reset (read register only)
//   we_i, be_i        : write strobe and byte-lane enables
//   waddr_i, wdata_i  : word write address and data
//   re_i, raddr_i     : read strobe and word read address
//   rdata_o           : registered read data, held while re_i is low
// The array itself is never reset.
module data_mem_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= 32'h0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: services CPU loads/stores on a byte-addressed,
// word-organised RAM and lets a loader preload memory while the CPU is halted.
//   MEM_ACCESS_*         : CPU access port (read/write, address, store data,
//                          size) and registered load data back to the CPU
//   halt                 : holds the CPU pipeline off during a load session
//   ld_start/ld_done     : one-cycle pulses that open/close a load session
//   ld_valid/ld_addr/ld_data/ld_ready : loader word write, accepted when
//                          ld_valid && ld_ready
//   misalign_err/range_err : sticky error flags, cleared only by reset
// Handshake: a loader word is written on the rising edge where ld_valid and
// ld_ready are both high; ld_ready is high exactly while the FSM is in LOAD.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LOAD_DRAIN  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_ACCESS_READ_WRN,
  input  logic [15:0] MEM_ACCESS_ADDRESS_BUS,
  input  logic [31:0] MEM_ACCESS_DATA_OUT_BUS,
  input  logic [1:0]  MEM_ACCESS_SIZE,
  output logic [31:0] MEM_ACCESS_DATA_IN_BUS,
  output logic        halt,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [15:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_done,
  output logic        ld_ready,
  output logic        misalign_err,
  output logic        range_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LOAD_DRAIN > 1) ? $clog2(LOAD_DRAIN) : 1;

  ld_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic        halt_q, ld_ready_q;
  logic        mis_q, rng_q, rd_zero_q;

  // CPU-side decode
  logic        cpu_rd, cpu_mis, cpu_oor, cpu_we;
  logic [13:0] cpu_widx;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;

  // Loader-side decode
  logic [13:0] ld_widx;
  logic        ld_oor, ld_we, in_load;
  logic        unused_ld_lsbs;

  // RAM port
  logic          ram_we, ram_re;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata, ram_rdata;

  assign cpu_rd   = (MEM_ACCESS_READ_WRN == MEM_READ);
  assign cpu_widx = MEM_ACCESS_ADDRESS_BUS[15:2];
  assign cpu_oor  = (32'(cpu_widx) >= 32'(DEPTH_WORDS));
  assign cpu_be   = lane_enables(MEM_ACCESS_SIZE, MEM_ACCESS_ADDRESS_BUS[1:0]);

  always_comb begin
    cpu_mis   = 1'b0;
    cpu_wdata = MEM_ACCESS_DATA_OUT_BUS;
    case (MEM_ACCESS_SIZE)
      SIZE_HALF: begin
        cpu_mis   = MEM_ACCESS_ADDRESS_BUS[0];
        cpu_wdata = {2{MEM_ACCESS_DATA_OUT_BUS[15:0]}};
      end
      SIZE_BYTE: cpu_wdata = {4{MEM_ACCESS_DATA_OUT_BUS[7:0]}};
      default:   cpu_mis   = (MEM_ACCESS_ADDRESS_BUS[1:0] != 2'b00);
    endcase
  end

  assign in_load = (state_q == ST_LOAD);
  // CPU stores still retire in DRAIN; they are ignored once the loader owns memory.
  assign cpu_we  = !cpu_rd && !cpu_mis && !cpu_oor && !in_load;

  assign ld_widx        = ld_addr[15:2];
  assign ld_oor         = (32'(ld_widx) >= 32'(DEPTH_WORDS));
  assign ld_we          = in_load && ld_valid && !ld_oor;
  assign unused_ld_lsbs = &{1'b0, ld_addr[1:0]};

  assign ram_we    = in_load ? ld_we : cpu_we;
  assign ram_be    = in_load ? 4'b1111 : cpu_be;
  assign ram_waddr = in_load ? ld_widx[AW-1:0] : cpu_widx[AW-1:0];
  assign ram_wdata = in_load ? ld_data : cpu_wdata;
  assign ram_re    = cpu_rd && !cpu_oor;

  data_mem_ram #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (cpu_widx[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Loader FSM with registered halt/ld_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      halt_q     <= 1'b0;
      ld_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ld_start) begin
            state_q <= ST_DRAIN;
            cnt_q   <= CW'(LOAD_DRAIN - 1);
            halt_q  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == '0) begin
            state_q    <= ST_LOAD;
            ld_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_LOAD: begin
          // A write in the same cycle as ld_done is performed by ld_we above.
          if (ld_done) begin
            state_q    <= ST_IDLE;
            halt_q     <= 1'b0;
            ld_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          halt_q     <= 1'b0;
          ld_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags, and a marker that forces the returned word to zero after an
  // out-of-range read. The marker only updates on reads so the output holds
  // through write cycles, matching the held RAM read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q     <= 1'b0;
      rng_q     <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      if (cpu_mis) mis_q <= 1'b1;
      if (cpu_oor) rng_q <= 1'b1;
      if (cpu_rd)  rd_zero_q <= cpu_oor;
    end
  end

  assign MEM_ACCESS_DATA_IN_BUS = rd_zero_q ? 32'h0 : ram_rdata;
  assign halt         = halt_q;
  assign ld_ready     = ld_ready_q;
  assign misalign_err = mis_q;
  assign range_err    = rng_q;

endmodule
